vtc_aligned: RTL and testbench

- Parametrised successor to the current video timing controller.
- Generates horizontal and vertical counters, active-video and sync signals for any VGA-style mode.
- Adds programmable sync polarity, a pixel clock-enable, start-of-frame and end-of-line strobes, and a free-running frame counter.
- Adds a DELAY-stage pipeline that re-times active and sync to match the latency of the downstream pattern generator.
- Sits between the PLL/reset synchroniser and the pattern generator in the video top level.

---
 rtl/vtc_aligned.sv | 151 +++++++++++++++
 tb/tb_vtc_aligned.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vtc_aligned.sv
// vtc_aligned: video timing controller with counter-aligned flags.
// Ports: clock/rst/en in; hPixel, vLine, vActive, hSync, vSync, sof,
// eol, activeD, hSyncD, vSyncD, frameCount out.
module vtc_aligned #(
  parameter int hArea    = 640,
  parameter int hFPorch  = 16,
  parameter int hSTime   = 96,
  parameter int hBPorch  = 48,
  parameter int vArea    = 480,
  parameter int vFPorch  = 10,
  parameter int vSTime   = 2,
  parameter int vBPorch  = 33,
  parameter bit hSyncPol = 1'b0,
  parameter bit vSyncPol = 1'b0,
  parameter int DELAY    = 2,
  parameter int CW       = 10,
  parameter int FCW      = 8
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           en,
  output logic [CW-1:0]  hPixel,
  output logic [CW-1:0]  vLine,
  output logic           vActive,
  output logic           hSync,
  output logic           vSync,
  output logic           sof,
  output logic           eol,
  output logic           activeD,
  output logic           hSyncD,
  output logic           vSyncD,
  output logic [FCW-1:0] frameCount
);

  localparam int HT = hArea + hFPorch + hSTime + hBPorch;
  localparam int VT = vArea + vFPorch + vSTime + vBPorch;
  localparam int HV_MAX = (HT > VT) ? HT : VT;

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_AREA = CW'(hArea);
  localparam logic [CW-1:0] V_AREA = CW'(vArea);
  localparam logic [CW-1:0] HS_BEG = CW'(hArea + hFPorch);
  localparam logic [CW-1:0] HS_END = CW'(hArea + hFPorch + hSTime);
  localparam logic [CW-1:0] VS_BEG = CW'(vArea + vFPorch);
  localparam logic [CW-1:0] VS_END = CW'(vArea + vFPorch + vSTime);

  if (hArea == 0 || hFPorch == 0 || hSTime == 0 || hBPorch == 0 ||
      vArea == 0 || vFPorch == 0 || vSTime == 0 || vBPorch == 0)
  begin : g_bad_zero
    $error("vtc_aligned: timing parameters must be non-zero");
  end

  if ((longint'(1) << CW) < longint'(HV_MAX)) begin : g_bad_cw
    $error("vtc_aligned: CW too small for line/frame totals");
  end

  if (DELAY < 0 || DELAY > 8) begin : g_bad_delay
    $error("vtc_aligned: DELAY must be 0..8");
  end

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_last;
  logic          v_last;
  logic          f_wrap;
  logic          act_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          eol_nxt;

  // Flags are decoded from the next-state counters so that, once
  // registered, they line up with the counter values they describe.
  always_comb begin
    h_last  = (hPixel == H_LAST);
    v_last  = (vLine == V_LAST);
    f_wrap  = h_last && v_last;
    h_nxt   = h_last ? '0 : hPixel + CW'(1);
    v_nxt   = vLine;
    if (h_last) begin
      v_nxt = v_last ? '0 : vLine + CW'(1);
    end
    act_nxt = (h_nxt < H_AREA) && (v_nxt < V_AREA);
    hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ?
              hSyncPol : ~hSyncPol;
    vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ?
              vSyncPol : ~vSyncPol;
    eol_nxt = (h_nxt == H_LAST);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      hPixel     <= '0;
      vLine      <= '0;
      frameCount <= '0;
      vActive    <= 1'b1;
      hSync      <= ~hSyncPol;
      vSync      <= ~vSyncPol;
      sof        <= 1'b0;
      eol        <= 1'b0;
    end else if (en) begin
      hPixel  <= h_nxt;
      vLine   <= v_nxt;
      vActive <= act_nxt;
      hSync   <= hs_nxt;
      vSync   <= vs_nxt;
      // next position 0,0 is exactly a frame wrap
      sof     <= f_wrap;
      eol     <= eol_nxt;
      if (f_wrap) begin
        frameCount <= frameCount + FCW'(1);
      end
    end else begin
      // strobes never stretch across a stalled cycle
      sof <= 1'b0;
      eol <= 1'b0;
    end
  end

  if (DELAY == 0) begin : g_nodly
    assign activeD = vActive;
    assign hSyncD  = hSync;
    assign vSyncD  = vSync;
  end else begin : g_dly
    logic [DELAY-1:0] a_q;
    logic [DELAY-1:0] h_q;
    logic [DELAY-1:0] v_q;

    always_ff @(posedge clock) begin
      if (rst) begin
        a_q <= '0;
        h_q <= {DELAY{~hSyncPol}};
        v_q <= {DELAY{~vSyncPol}};
      end else if (en) begin
        a_q[0] <= vActive;
        h_q[0] <= hSync;
        v_q[0] <= vSync;
        for (int i = 1; i < DELAY; i++) begin
          a_q[i] <= a_q[i-1];
          h_q[i] <= h_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign activeD = a_q[DELAY-1];
    assign hSyncD  = h_q[DELAY-1];
    assign vSyncD  = v_q[DELAY-1];
  end

endmodule

// File: tb/tb_vtc_aligned.sv
// tb_vtc_aligned: scoreboard bench for vtc_aligned in a small mode.
// Two instances: active-low syncs/DELAY=2/FCW=8 and active-high/DELAY=0/FCW=2.
module tb_vtc_aligned;

  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic [CW-1:0] m_h, m_v, a_h, a_v;
  logic          m_act, m_hs, m_vs, m_sof, m_eol, m_ad, m_hd, m_vd;
  logic          a_act, a_hs, a_vs, a_sof, a_eol, a_ad, a_hd, a_vd;
  logic [7:0]    m_fc;
  logic [1:0]    a_fc;

  vtc_aligned #(
    .hArea(8), .hFPorch(2), .hSTime(3), .hBPorch(1),
    .vArea(4), .vFPorch(1), .vSTime(2), .vBPorch(1),
    .hSyncPol(1'b0), .vSyncPol(1'b0), .DELAY(2), .CW(CW), .FCW(8)
  ) u_main (
    .clock(clk), .rst(rst), .en(en),
    .hPixel(m_h), .vLine(m_v), .vActive(m_act),
    .hSync(m_hs), .vSync(m_vs), .sof(m_sof), .eol(m_eol),
    .activeD(m_ad), .hSyncD(m_hd), .vSyncD(m_vd),
    .frameCount(m_fc)
  );

  vtc_aligned #(
    .hArea(8), .hFPorch(2), .hSTime(3), .hBPorch(1),
    .vArea(4), .vFPorch(1), .vSTime(2), .vBPorch(1),
    .hSyncPol(1'b1), .vSyncPol(1'b1), .DELAY(0), .CW(CW), .FCW(2)
  ) u_alt (
    .clock(clk), .rst(rst), .en(en),
    .hPixel(a_h), .vLine(a_v), .vActive(a_act),
    .hSync(a_hs), .vSync(a_vs), .sof(a_sof), .eol(a_eol),
    .activeD(a_ad), .hSyncD(a_hd), .vSyncD(a_vd),
    .frameCount(a_fc)
  );

  typedef struct {
    int h; int v; int f;
    bit act; bit hs; bit vs; bit sof; bit eol;
    bit ad; bit hd; bit vd;
  } exp_t;

  exp_t q[$];
  int   asof_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   phase = 0;

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // reference model state: position and enabled-cycle history
  int h = 0, v = 0, f = 0;
  bit s_sof = 0, s_eol = 0;
  bit pa0 = 0, pa1 = 0, ph0 = 1, ph1 = 1, pv0 = 1, pv1 = 1;

  function automatic bit f_act(int hh, int vv);
    return (hh < 8) && (vv < 4);
  endfunction

  // active-low syncs: low at hPixel 10..12 and vLine 5..6
  function automatic bit f_hs(int hh);
    return !(hh >= 10 && hh <= 12);
  endfunction

  function automatic bit f_vs(int vv);
    return !(vv >= 5 && vv <= 6);
  endfunction

  task automatic step(bit r, bit e);
    exp_t x;
    rst = r;
    en  = e;
    if (r) begin
      h = 0; v = 0; f = 0;
      s_sof = 0; s_eol = 0;
      pa0 = 0; pa1 = 0; ph0 = 1; ph1 = 1; pv0 = 1; pv1 = 1;
    end else if (e) begin
      pa1 = pa0; pa0 = f_act(h, v);
      ph1 = ph0; ph0 = f_hs(h);
      pv1 = pv0; pv0 = f_vs(v);
      h++;
      if (h == 14) begin
        h = 0; v++;
        if (v == 8) begin
          v = 0; f++;
        end
      end
      s_sof = (h == 0) && (v == 0);
      s_eol = (h == 13);
    end else begin
      s_sof = 0; s_eol = 0;
    end
    x.h = h; x.v = v; x.f = f;
    x.act = f_act(h, v); x.hs = f_hs(h); x.vs = f_vs(v);
    x.sof = s_sof; x.eol = s_eol;
    x.ad = pa1; x.hd = ph1; x.vd = pv1;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // monitor: per-cycle scoreboard plus per-frame directed counts
  int cyc = 0, last_sof = -1, prev_phase = 0;
  int act_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (phase != prev_phase) begin
      last_sof = -1;
      prev_phase = phase;
    end
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("hPixel", int'(m_h), x.h);
      chk("vLine", int'(m_v), x.v);
      chk("frameCount", int'(m_fc), x.f % 256);
      chk("vActive", int'(m_act), int'(x.act));
      chk("hSync", int'(m_hs), int'(x.hs));
      chk("vSync", int'(m_vs), int'(x.vs));
      chk("sof", int'(m_sof), int'(x.sof));
      chk("eol", int'(m_eol), int'(x.eol));
      chk("activeD", int'(m_ad), int'(x.ad));
      chk("hSyncD", int'(m_hd), int'(x.hd));
      chk("vSyncD", int'(m_vd), int'(x.vd));
      chk("alt_hPixel", int'(a_h), x.h);
      chk("alt_vLine", int'(a_v), x.v);
      chk("alt_frameCount", int'(a_fc), x.f % 4);
      chk("alt_vActive", int'(a_act), int'(x.act));
      chk("alt_hSync", int'(a_hs), int'(!x.hs));
      chk("alt_vSync", int'(a_vs), int'(!x.vs));
      chk("alt_sof", int'(a_sof), int'(x.sof));
      chk("alt_eol", int'(a_eol), int'(x.eol));
      chk("alt_activeD", int'(a_ad), int'(x.act));
      chk("alt_hSyncD", int'(a_hd), int'(!x.hs));
      chk("alt_vSyncD", int'(a_vd), int'(!x.vs));
    end
    if (a_sof) asof_q.push_back(int'(a_fc));
    if (m_sof) begin
      if (last_sof >= 0 && phase == 1) begin
        chk("sof_period_en1", cyc - last_sof, 112);
        chk("active_per_frame", act_cnt, 32);
        chk("hsync_low_per_frame", hs_cnt, 24);
        chk("vsync_low_per_frame", vs_cnt, 28);
      end
      if (last_sof >= 0 && phase == 2) begin
        chk("sof_period_toggle", cyc - last_sof, 224);
      end
      last_sof = cyc;
      act_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end
    if (m_act) act_cnt++;
    if (!m_hs) hs_cnt++;
    if (!m_vs) vs_cnt++;
  end

  initial begin
    int seq[5];
    int guard;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;

    repeat (3) step(1'b1, 1'b1);
    phase = 1;
    repeat (112 * 3 + 5) step(1'b0, 1'b1);

    phase = 2;
    for (int i = 0; i < 224 * 2 + 20; i++) begin
      step(1'b0, (i % 2) == 0);
    end

    phase = 3;
    guard = 0;
    while (!(h == 6 && v == 3 && f == 5) && guard < 400) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("midframe_reached", guard < 400, 1);
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1);
    phase = 0;

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("scoreboard_drained", q.size(), 0);

    chk("alt_sof_count", asof_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < asof_q.size()) chk("alt_fc_seq", asof_q[i], seq[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
